// File: rtl/ifu_prefetch_buf.sv
// Instruction-fetch prefetch buffer: issues sequential reads to a 1-cycle
// synchronous instruction ROM, queues the returned words with their PCs in a
// small FIFO and presents the head to decode over a valid/ready handshake.
// A jump from execute flushes the FIFO, drops any in-flight read and redirects.
module ifu_prefetch_buf #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,    // power of two, >= 2
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  output logic              rom_rd_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_W-1:0] NOP_INST   = DATA_W'(32'h0000_0013);
  localparam logic [ADDR_W-1:0] RESET_PC_A = {RESET_PC[ADDR_W-1:2], 2'b00};

  // Fetch state
  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  // FIFO state
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_mem_inst [DEPTH];
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];

  logic [CNT_W:0]    w_credit;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_nonempty;
  logic [1:0]        w_unused_jump_lsb;

  // Target is forced word-aligned, so the two low bits are intentionally dropped.
  assign w_unused_jump_lsb = jump_addr_i[1:0];

  // Slots already spoken for: entries held plus the read whose data arrives next
  // cycle. Same-cycle pops are not credited so the ROM strobe never depends on
  // inst_ready_i. Gating with rst keeps the strobe low while reset is asserted.
  assign w_credit   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_issue    = rst & ~jump_en_i & (w_credit < (CNT_W+1)'(DEPTH));
  assign w_push     = r_inflight & ~jump_en_i;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty & inst_ready_i & ~jump_en_i;

  assign rom_rd_en_o  = w_issue;
  assign rom_addr_o   = r_pc;
  assign inst_valid_o = w_nonempty;
  assign inst_o       = w_nonempty ? r_mem_inst[r_rd_ptr] : NOP_INST;
  assign inst_addr_o  = w_nonempty ? r_mem_addr[r_rd_ptr] : '0;

  // PC advance, redirect and tracking of the single outstanding ROM read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC_A;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (jump_en_i) begin
      r_pc       <= {jump_addr_i[ADDR_W-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + ADDR_W'(4);
        r_inflight_pc <= r_pc;
      end
    end
  end

  // FIFO pointers and occupancy; a jump flushes and ignores any pop that cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (jump_en_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // FIFO storage: the ROM word is paired with the PC it was fetched from
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= rom_data_i;
      r_mem_addr[r_wr_ptr] <= r_inflight_pc;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// Directed testbench for ifu_prefetch_buf. Cycles run posedge to posedge:
// inputs change 1 time unit after the edge, outputs are sampled 1 unit later.
// The ROM model returns ~addr so that data/address mixups are visible.
module tb_ifu_prefetch_buf;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        rom_rd_en_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected values for the current cycle
  logic        er;
  logic [31:0] era;
  logic        ev;
  logic [31:0] ea;
  logic [31:0] ei;

  ifu_prefetch_buf #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .rom_rd_en_o(rom_rd_en_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1-cycle synchronous ROM
  always @(posedge clk) begin
    if (rom_rd_en_o) rom_data_i <= ~rom_addr_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset 3 cycles, releases it 1 unit after an edge: that cycle is C0
  task automatic reset_dut(input logic rdy);
    rst          = 1'b0;
    jump_en_i    = 1'b0;
    jump_addr_i  = '0;
    inst_ready_i = rdy;
    repeat (3) step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    jump_en_i    = 1'b0;
    jump_addr_i  = '0;
    inst_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      n_tests++;
      if (rom_rd_en_o !== 1'b0 || rom_addr_o !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rom cyc %0d: rd_en=%b addr=%h, want rd_en=0 addr=00000000", k, rom_rd_en_o, rom_addr_o);
      end
      n_tests++;
      if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_head cyc %0d: valid=%b inst=%h addr=%h, want 0/%h/00000000", k, inst_valid_o, inst_o, inst_addr_o, NOP);
      end
      $display("[TB] reset cyc %0d rd_en=%b rom_addr=%h valid=%b", k, rom_rd_en_o, rom_addr_o, inst_valid_o);
    end
  endtask

  // Sequential streaming with ready=1: rom_addr 0,4,8.. each cycle, head lags 2 cycles
  task automatic test_sequential();
    reset_dut(1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      #1;
      er  = 1'b1;
      era = 32'(4 * k);
      ev  = (k >= 2);
      ea  = (k >= 2) ? 32'(4 * (k - 2)) : 32'h0;
      ei  = (k >= 2) ? ~ea : NOP;
      n_tests++;
      if (rom_rd_en_o !== er || rom_addr_o !== era) begin
        n_fail++;
        $display("FAIL seq_rom cyc %0d: rd_en=%b addr=%h, want rd_en=%b addr=%h", k, rom_rd_en_o, rom_addr_o, er, era);
      end
      n_tests++;
      if (inst_valid_o !== ev || inst_addr_o !== ea || inst_o !== ei) begin
        n_fail++;
        $display("FAIL seq_head cyc %0d: valid=%b addr=%h inst=%h, want %b/%h/%h", k, inst_valid_o, inst_addr_o, inst_o, ev, ea, ei);
      end
      $display("[TB] seq cyc %0d rom_addr=%h head_valid=%b head_addr=%h", k, rom_addr_o, inst_valid_o, inst_addr_o);
    end
  endtask

  // ready=0: exactly 4 issues, then stall; one pop frees exactly one issue at 16
  task automatic test_backpressure();
    reset_dut(1'b0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      inst_ready_i = (k == 6);
      #1;
      er  = (k < 4) || (k == 7);
      era = (k < 4) ? 32'(4 * k) : (k <= 7) ? 32'd16 : 32'd20;
      ev  = (k >= 2);
      ea  = (k >= 7) ? 32'd4 : 32'd0;
      ei  = (k >= 2) ? ~ea : NOP;
      n_tests++;
      if (rom_rd_en_o !== er || rom_addr_o !== era) begin
        n_fail++;
        $display("FAIL bp_rom cyc %0d: rd_en=%b addr=%h, want rd_en=%b addr=%h", k, rom_rd_en_o, rom_addr_o, er, era);
      end
      n_tests++;
      if (inst_valid_o !== ev || inst_addr_o !== ea || inst_o !== ei) begin
        n_fail++;
        $display("FAIL bp_head cyc %0d: valid=%b addr=%h inst=%h, want %b/%h/%h", k, inst_valid_o, inst_addr_o, inst_o, ev, ea, ei);
      end
      $display("[TB] bp cyc %0d ready=%b rd_en=%b rom_addr=%h head_addr=%h", k, inst_ready_i, rom_rd_en_o, rom_addr_o, inst_addr_o);
    end
  endtask

  // Fill to full with ready=0, then sustain ready=1: heads must run +4 with no gap
  task automatic test_full_stream();
    reset_dut(1'b0);
    for (int k = 0; k < 18; k++) begin
      if (k > 0) step();
      inst_ready_i = (k >= 5);
      #1;
      if (k >= 5) begin
        er  = (k >= 6);
        era = (k >= 6) ? 32'(16 + 4 * (k - 6)) : 32'd16;
        ev  = 1'b1;
        ea  = 32'(4 * (k - 5));
        ei  = ~ea;
        n_tests++;
        if (rom_rd_en_o !== er || rom_addr_o !== era) begin
          n_fail++;
          $display("FAIL full_rom cyc %0d: rd_en=%b addr=%h, want rd_en=%b addr=%h", k, rom_rd_en_o, rom_addr_o, er, era);
        end
        n_tests++;
        if (inst_valid_o !== ev || inst_addr_o !== ea || inst_o !== ei) begin
          n_fail++;
          $display("FAIL full_head cyc %0d: valid=%b addr=%h inst=%h, want %b/%h/%h", k, inst_valid_o, inst_addr_o, inst_o, ev, ea, ei);
        end
        $display("[TB] full cyc %0d rom_addr=%h head_addr=%h", k, rom_addr_o, inst_addr_o);
      end
    end
  endtask

  // Jump to 0x103 while the read of 0x20 is in flight: 0x20 is dropped
  task automatic test_jump();
    reset_dut(1'b1);
    for (int k = 0; k < 15; k++) begin
      if (k > 0) step();
      jump_en_i   = (k == 9);
      jump_addr_i = (k == 9) ? 32'h0000_0103 : 32'h0;
      #1;
      er  = (k != 9);
      era = (k < 9) ? 32'(4 * k) : (k == 9) ? 32'd36 : 32'(32'h100 + 4 * (k - 10));
      ev  = (k >= 2 && k <= 9) || (k >= 12);
      ea  = (k >= 2 && k <= 9) ? 32'(4 * (k - 2)) : (k >= 12) ? 32'(32'h100 + 4 * (k - 12)) : 32'h0;
      ei  = ev ? ~ea : NOP;
      n_tests++;
      if (rom_rd_en_o !== er || rom_addr_o !== era) begin
        n_fail++;
        $display("FAIL jump_rom cyc %0d: rd_en=%b addr=%h, want rd_en=%b addr=%h", k, rom_rd_en_o, rom_addr_o, er, era);
      end
      n_tests++;
      if (inst_valid_o !== ev || inst_addr_o !== ea || inst_o !== ei) begin
        n_fail++;
        $display("FAIL jump_head cyc %0d: valid=%b addr=%h inst=%h, want %b/%h/%h", k, inst_valid_o, inst_addr_o, inst_o, ev, ea, ei);
      end
      $display("[TB] jump cyc %0d jump=%b rom_addr=%h head_valid=%b head_addr=%h", k, jump_en_i, rom_addr_o, inst_valid_o, inst_addr_o);
    end
    jump_en_i = 1'b0;
  endtask

  // Jumps to 0x40 then 0x80 on consecutive cycles: only the 0x80 stream emerges
  task automatic test_back_to_back();
    reset_dut(1'b1);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      jump_en_i   = (k == 4) || (k == 5);
      jump_addr_i = (k == 4) ? 32'h40 : (k == 5) ? 32'h80 : 32'h0;
      #1;
      er  = (k != 4) && (k != 5);
      era = (k < 4) ? 32'(4 * k) : (k == 4) ? 32'd16 : (k == 5) ? 32'h40 : 32'(32'h80 + 4 * (k - 6));
      ev  = (k >= 2 && k <= 4) || (k >= 8);
      ea  = (k >= 2 && k <= 4) ? 32'(4 * (k - 2)) : (k >= 8) ? 32'(32'h80 + 4 * (k - 8)) : 32'h0;
      ei  = ev ? ~ea : NOP;
      n_tests++;
      if (rom_rd_en_o !== er || rom_addr_o !== era) begin
        n_fail++;
        $display("FAIL b2b_rom cyc %0d: rd_en=%b addr=%h, want rd_en=%b addr=%h", k, rom_rd_en_o, rom_addr_o, er, era);
      end
      n_tests++;
      if (inst_valid_o !== ev || inst_addr_o !== ea || inst_o !== ei) begin
        n_fail++;
        $display("FAIL b2b_head cyc %0d: valid=%b addr=%h inst=%h, want %b/%h/%h", k, inst_valid_o, inst_addr_o, inst_o, ev, ea, ei);
      end
      $display("[TB] b2b cyc %0d jump=%b rom_addr=%h head_valid=%b head_addr=%h", k, jump_en_i, rom_addr_o, inst_valid_o, inst_addr_o);
    end
    jump_en_i = 1'b0;
  endtask

  // Reset asserted mid-cycle with the FIFO half full; refetch restarts at 0
  task automatic test_async_reset();
    reset_dut(1'b0);
    step();
    step();
    step();
    #1;
    n_tests++;
    if (inst_valid_o !== 1'b1 || rom_addr_o !== 32'd12) begin
      n_fail++;
      $display("FAIL arst_pre: valid=%b rom_addr=%h, want 1/0000000c", inst_valid_o, rom_addr_o);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (rom_rd_en_o !== 1'b0 || rom_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_rom: rd_en=%b addr=%h, want 0/00000000", rom_rd_en_o, rom_addr_o);
    end
    n_tests++;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_head: valid=%b inst=%h addr=%h, want 0/%h/00000000", inst_valid_o, inst_o, inst_addr_o, NOP);
    end
    $display("[TB] arst asserted rd_en=%b rom_addr=%h valid=%b", rom_rd_en_o, rom_addr_o, inst_valid_o);
    inst_ready_i = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      #1;
      ev = (k >= 2);
      ea = (k >= 2) ? 32'(4 * (k - 2)) : 32'h0;
      ei = ev ? ~ea : NOP;
      n_tests++;
      if (rom_rd_en_o !== 1'b1 || rom_addr_o !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL arst_refetch_rom cyc %0d: rd_en=%b addr=%h, want 1/%h", k, rom_rd_en_o, rom_addr_o, 32'(4 * k));
      end
      n_tests++;
      if (inst_valid_o !== ev || inst_addr_o !== ea || inst_o !== ei) begin
        n_fail++;
        $display("FAIL arst_refetch_head cyc %0d: valid=%b addr=%h inst=%h, want %b/%h/%h", k, inst_valid_o, inst_addr_o, inst_o, ev, ea, ei);
      end
      $display("[TB] arst refetch cyc %0d rom_addr=%h head_addr=%h", k, rom_addr_o, inst_addr_o);
    end
  endtask

  initial begin
    rst          = 1'b0;
    jump_en_i    = 1'b0;
    jump_addr_i  = '0;
    inst_ready_i = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_full_stream();
    test_jump();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
